uart_conv_frame_encoder: RTL and testbench
==========================================

UART_CONV_FRAME_ENCODER -- requirements
Module: uart_conv_frame_encoder

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 4, number of received bytes per frame (1..32).
REQ-002 SHALL have parameter K, default 3, convolutional constraint length (3..7).
REQ-003 SHALL have parameter G0, default 7, generator polynomial for output bit c0 (K bits; bit 0 = current input, bit k = input delayed k).
REQ-004 SHALL have parameter G1, default 5, generator polynomial for output bit c1 (same bit convention).
REQ-005 SHALL have parameter TAIL, default 1, which when 1 appends K-1 zero flush bits per frame.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe from the UART receiver: rx_data is valid.
REQ-009 SHALL have port rx_data  input  8  received byte.
REQ-010 SHALL have port abort  input  1  debounced synchronous frame discard.
REQ-011 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-012 SHALL have port tx_start  output  1  one-cycle send strobe to the transmitter.
REQ-013 SHALL have port tx_data  output  8  byte to transmit; stable while tx_start is high.
REQ-014 SHALL have port busy  output  1  high in ENCODE and SEND.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the last byte's tx_start.
REQ-016 SHALL have port overrun  output  1  sticky flag: a byte was dropped.

Function
REQ-017 SHALL run FSM COLLECT -> ENCODE -> SEND -> COLLECT.
REQ-018 COLLECT: each rx_valid SHALL store rx_data at index 0..PAYLOAD_BYTES-1; the Nth byte SHALL enter ENCODE on the next cycle with encoder shift state cleared.
REQ-019 ENCODE SHALL consume one input bit per cycle, byte 0 first, LSB first, then TAIL zero bits; L = 8*PAYLOAD_BYTES + TAIL*(K-1) cycles.
REQ-020 For input bit i: c0 = XOR of taps selected by G0, c1 = XOR of taps selected by G1, written to output bit 2i (c0) and 2i+1 (c1).
REQ-021 Output byte count SHALL be M = ceil(2L/8); pad bits SHALL be 0; output byte j = bits 8j+7..8j.
REQ-022 SEND SHALL issue byte 0..M-1 in order; tx_start only when tx_busy=0; after each strobe tx_busy SHALL be ignored for one guard cycle.
REQ-023 frame_done SHALL pulse the cycle after the final guard cycle; FSM SHALL then return to COLLECT with byte index 0.
REQ-024 tx_busy held high SHALL stall SEND indefinitely with no lost or repeated bytes.
REQ-025 rx_valid in ENCODE or SEND SHALL be dropped and SHALL set overrun.
REQ-026 abort in any state SHALL, next cycle, enter COLLECT, clear byte index, encoder state and overrun, and suppress tx_start; abort wins over simultaneous rx_valid.
REQ-027 An in-flight UART byte at abort SHALL complete in the transmitter; no new tx_start follows.

Reset
REQ-028 rst_n low SHALL asynchronously force COLLECT, tx_start=0, tx_data=0x00, busy=0, frame_done=0, overrun=0, all counters and encoder state to 0.
REQ-029 Deassertion SHALL be synchronised externally; first rx_valid after release SHALL be accepted as byte 0.

Structure
REQ-030 Package enc_bridge_pkg SHALL hold the FSM state enum and a constant function computing M from PAYLOAD_BYTES, K, TAIL.
REQ-031 Sub-module conv_enc_core (parameters K, G0, G1) SHALL hold the K-1 bit shift register and produce {c1,c0} combinationally with clear and enable inputs.
REQ-032 Payload and output buffers SHALL be flat registers sized from the parameters; no memories.

Verification
REQ-033 PAYLOAD_BYTES=1, K=3, G0=7, G1=5, TAIL=0; rx 0x01 -> tx 0x37, 0x00; frame_done once.
REQ-034 Same with TAIL=1 -> tx 0x37, 0x00, 0x00 (M=3).
REQ-035 PAYLOAD_BYTES=4 defaults; rx 00 00 00 00 -> 9 bytes of 0x00; busy high from 5th cycle after last rx_valid-entry through frame_done.
REQ-036 Hold tx_busy=1 for 500 cycles mid-SEND -> no tx_start during hold; remaining bytes correct afterwards.
REQ-037 rx_valid during ENCODE -> overrun=1, output unchanged; abort -> overrun=0, COLLECT.
REQ-038 abort after 2nd tx_start, then rst_n pulse mid-COLLECT -> no further tx_start; all outputs at reset values.

Source files
------------

// File: rtl/enc_bridge_pkg.sv
// Shared FSM state type and frame-size helpers for the UART convolutional frame encoder.
package enc_bridge_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ENCODE  = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    // Encoder cycles per frame: payload bits plus optional K-1 flush zeros.
    function automatic int calc_len(input int payload_bytes, input int k, input int tail);
        return 8 * payload_bytes + tail * (k - 1);
    endfunction

    // Output bytes per frame: two code bits per input bit, rounded up to whole bytes.
    function automatic int calc_m(input int payload_bytes, input int k, input int tail);
        return (2 * calc_len(payload_bytes, k, tail) + 7) / 8;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 convolutional encoder: {c1,c0} is combinational from the current bit and a K-1 bit history.
// History advances on en_i; clr_i empties it and takes priority.
module conv_enc_core #(
    parameter int K  = 3,
    parameter int G0 = 7,
    parameter int G1 = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [1:0] code_o
);

    localparam logic [K-1:0] G0_M = K'(G0);
    localparam logic [K-1:0] G1_M = K'(G1);

    logic [K-2:0] sr_q;
    logic [K-2:0] sr_d;
    logic [K-1:0] taps;

    // Tap bit 0 is the current input, tap bit k the input delayed by k cycles.
    assign taps   = {sr_q, bit_i};
    assign sr_d   = {sr_q[K-3:0], bit_i};
    assign code_o = {^(taps & G1_M), ^(taps & G0_M)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clr_i) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/uart_conv_frame_encoder.sv
// Collects PAYLOAD_BYTES from a UART receiver, convolutionally encodes them one bit per cycle,
// then streams the coded bytes out, waiting on tx_busy with a one-cycle guard after each strobe.
module uart_conv_frame_encoder
    import enc_bridge_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 4,
    parameter int K             = 3,
    parameter int G0            = 7,
    parameter int G1            = 5,
    parameter int TAIL          = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       abort,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int L_BITS  = calc_len(PAYLOAD_BYTES, K, TAIL);
    localparam int M_BYTES = calc_m(PAYLOAD_BYTES, K, TAIL);
    localparam int PW      = 8 * PAYLOAD_BYTES;
    localparam int OW      = 8 * M_BYTES;
    localparam int PAD     = OW - 2 * L_BITS;
    localparam int BW      = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int LW      = $clog2(L_BITS);
    localparam int MW      = (M_BYTES > 1) ? $clog2(M_BYTES) : 1;

    localparam logic [BW-1:0] B_LAST = BW'(PAYLOAD_BYTES - 1);
    localparam logic [LW-1:0] L_LAST = LW'(L_BITS - 1);
    localparam logic [MW-1:0] M_LAST = MW'(M_BYTES - 1);

    state_t        state_q;
    logic [BW-1:0] bidx_q;
    logic [LW-1:0] bit_cnt_q;
    logic [MW-1:0] obyte_q;
    logic [PW-1:0] pbuf_q;
    logic [OW-1:0] obuf_q;
    logic          guard_q;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
    logic          busy_q;
    logic          frame_done_q;
    logic          overrun_q;

    logic [PW-1:0] pbuf_ld_d;
    logic [OW-1:0] obuf_sh_d;
    logic [1:0]    enc_code;

    // New bytes enter at the top so byte 0 ends up in the low lanes; the encoder
    // then drains pbuf from bit 0, which also yields the zero tail bits for free.
    assign pbuf_ld_d = (pbuf_q >> 8) | (PW'(rx_data) << (PW - 8));
    // Code pairs enter at the top; after L shifts the first pair sits PAD bits up.
    assign obuf_sh_d = {enc_code, obuf_q[OW-1:2]};

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (abort || (state_q != ST_ENCODE)),
        .en_i   (state_q == ST_ENCODE),
        .bit_i  (pbuf_q[0]),
        .code_o (enc_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_COLLECT;
            bidx_q       <= '0;
            bit_cnt_q    <= '0;
            obyte_q      <= '0;
            pbuf_q       <= '0;
            obuf_q       <= '0;
            guard_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (abort) begin
            state_q      <= ST_COLLECT;
            bidx_q       <= '0;
            bit_cnt_q    <= '0;
            obyte_q      <= '0;
            guard_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (rx_valid) begin
                        pbuf_q <= pbuf_ld_d;
                        if (bidx_q == B_LAST) begin
                            bidx_q    <= '0;
                            bit_cnt_q <= '0;
                            obuf_q    <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_ENCODE;
                        end else begin
                            bidx_q <= bidx_q + BW'(1);
                        end
                    end
                end
                ST_ENCODE: begin
                    if (rx_valid) overrun_q <= 1'b1;
                    pbuf_q <= pbuf_q >> 1;
                    obuf_q <= obuf_sh_d;
                    if (bit_cnt_q == L_LAST) begin
                        obyte_q <= '0;
                        guard_q <= 1'b0;
                        state_q <= ST_SEND;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + LW'(1);
                    end
                end
                ST_SEND: begin
                    if (rx_valid) overrun_q <= 1'b1;
                    // Per byte: strobe cycle, guard cycle, then wait for tx_busy low.
                    if (frame_done_q) begin
                        frame_done_q <= 1'b0;
                        busy_q       <= 1'b0;
                        bidx_q       <= '0;
                        state_q      <= ST_COLLECT;
                    end else if (tx_start_q) begin
                        tx_start_q <= 1'b0;
                        guard_q    <= 1'b1;
                    end else if (guard_q) begin
                        guard_q <= 1'b0;
                        if (obyte_q == M_LAST) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            obyte_q <= obyte_q + MW'(1);
                        end
                    end else if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= 8'(obuf_q >> PAD);
                        obuf_q     <= obuf_q >> 8;
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_conv_frame_encoder.sv
// Directed bench: two single-byte configurations (TAIL 0/1) and the default configuration.
module tb_uart_conv_frame_encoder;

    logic       clk;
    logic       rst_n;

    logic       rx_valid_s, abort_s, tx_busy_s;
    logic [7:0] rx_data_s;
    logic       a_tx_start, a_busy, a_frame_done, a_overrun;
    logic [7:0] a_tx_data;
    logic       b_tx_start, b_busy, b_frame_done, b_overrun;
    logic [7:0] b_tx_data;

    logic       rx_valid_c, abort_c, tx_busy_c;
    logic [7:0] rx_data_c;
    logic       c_tx_start, c_busy, c_frame_done, c_overrun;
    logic [7:0] c_tx_data;

    int n_chk;
    int n_pass;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];
    int fda, fdb, fdc;
    logic [7:0] exp_c[9];

    uart_conv_frame_encoder #(.PAYLOAD_BYTES(1), .K(3), .G0(7), .G1(5), .TAIL(0)) u_a (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid_s), .rx_data(rx_data_s),
        .abort(abort_s), .tx_busy(tx_busy_s), .tx_start(a_tx_start), .tx_data(a_tx_data),
        .busy(a_busy), .frame_done(a_frame_done), .overrun(a_overrun)
    );

    uart_conv_frame_encoder #(.PAYLOAD_BYTES(1), .K(3), .G0(7), .G1(5), .TAIL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid_s), .rx_data(rx_data_s),
        .abort(abort_s), .tx_busy(tx_busy_s), .tx_start(b_tx_start), .tx_data(b_tx_data),
        .busy(b_busy), .frame_done(b_frame_done), .overrun(b_overrun)
    );

    uart_conv_frame_encoder u_c (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid_c), .rx_data(rx_data_c),
        .abort(abort_c), .tx_busy(tx_busy_c), .tx_start(c_tx_start), .tx_data(c_tx_data),
        .busy(c_busy), .frame_done(c_frame_done), .overrun(c_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_tx_start) qa.push_back(a_tx_data);
        if (b_tx_start) qb.push_back(b_tx_data);
        if (c_tx_start) qc.push_back(c_tx_data);
        if (a_frame_done) fda++;
        if (b_frame_done) fdb++;
        if (c_frame_done) fdc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic send_c(input logic [7:0] b);
        @(negedge clk);
        rx_valid_c = 1'b1;
        rx_data_c  = b;
        @(negedge clk);
        rx_valid_c = 1'b0;
    endtask

    task automatic send_frame_c();
        send_c(8'h03);
        send_c(8'h00);
        send_c(8'h00);
        send_c(8'h01);
    endtask

    task automatic wait_fd_c(input int target, input string tag);
        int k;
        k = 0;
        while (fdc < target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(fdc >= target), 1);
    endtask

    task automatic wait_two_starts_c(input string tag);
        int k;
        k = 0;
        while (qc.size() < 2 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(qc.size() >= 2), 1);
    endtask

    task automatic check_frame_c(input string tag);
        check({tag, " count"}, qc.size(), 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s byte%0d", tag, i), (i < qc.size()) ? qc[i] : 8'hxx, exp_c[i]);
    endtask

    initial begin
        int  fd_snap;
        int  n_hold;
        logic busy_ok;
        logic seen;

        n_chk = 0; n_pass = 0;
        fda = 0; fdb = 0; fdc = 0;
        // 03 00 00 01 with G=7/5, K=3, two tail bits.
        exp_c = '{8'hEB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00};
        rst_n = 1'b0;
        rx_valid_s = 1'b0; rx_data_s = 8'h00; abort_s = 1'b0; tx_busy_s = 1'b0;
        rx_valid_c = 1'b0; rx_data_c = 8'h00; abort_c = 1'b0; tx_busy_c = 1'b0;

        repeat (3) @(negedge clk);
        check("rst c tx_start", c_tx_start, 0);
        check("rst c tx_data", c_tx_data, 8'h00);
        check("rst c busy", c_busy, 0);
        check("rst c frame_done", c_frame_done, 0);
        check("rst c overrun", c_overrun, 0);
        check("rst a tx_start", a_tx_start, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-byte frames, TAIL=0 and TAIL=1.
        rx_valid_s = 1'b1; rx_data_s = 8'h01;
        @(negedge clk);
        rx_valid_s = 1'b0;
        for (int k = 0; k < 200 && (fda < 1 || fdb < 1); k++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("A count", qa.size(), 2);
        check("A byte0", (qa.size() > 0) ? qa[0] : 8'hxx, 8'h37);
        check("A byte1", (qa.size() > 1) ? qa[1] : 8'hxx, 8'h00);
        check("A frame_done", fda, 1);
        check("A busy idle", a_busy, 0);
        check("B count", qb.size(), 3);
        check("B byte0", (qb.size() > 0) ? qb[0] : 8'hxx, 8'h37);
        check("B byte1", (qb.size() > 1) ? qb[1] : 8'hxx, 8'h00);
        check("B byte2", (qb.size() > 2) ? qb[2] : 8'hxx, 8'h00);
        check("B frame_done", fdb, 1);

        // Default configuration, all-zero payload, busy window.
        qc.delete();
        send_c(8'h00); send_c(8'h00); send_c(8'h00); send_c(8'h00);
        busy_ok = 1'b1; seen = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (k >= 5 && c_busy !== 1'b1) busy_ok = 1'b0;
            if (c_frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("zero busy window", busy_ok, 1);
        check("zero frame_done seen", seen, 1);
        @(negedge clk);
        check("zero busy after", c_busy, 0);
        repeat (5) @(negedge clk);
        check("zero count", qc.size(), 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("zero byte%0d", i), (i < qc.size()) ? qc[i] : 8'hxx, 8'h00);

        // Stall SEND for 500 cycles after the second strobe.
        qc.delete();
        fd_snap = fdc;
        send_frame_c();
        wait_two_starts_c("stall reach send");
        tx_busy_c = 1'b1;
        n_hold = qc.size();
        repeat (500) @(negedge clk);
        check("stall no start", qc.size() - n_hold, 0);
        check("stall busy held", c_busy, 1);
        tx_busy_c = 1'b0;
        wait_fd_c(fd_snap + 1, "stall frame_done");
        repeat (3) @(negedge clk);
        check_frame_c("stall");

        // rx_valid during ENCODE is dropped and flagged.
        qc.delete();
        fd_snap = fdc;
        send_frame_c();
        repeat (3) @(negedge clk);
        send_c(8'hFF);
        check("overrun set", c_overrun, 1);
        wait_fd_c(fd_snap + 1, "overrun frame_done");
        repeat (3) @(negedge clk);
        check_frame_c("overrun");
        check("overrun sticky", c_overrun, 1);
        @(negedge clk); abort_c = 1'b1;
        @(negedge clk); abort_c = 1'b0;
        check("abort clears overrun", c_overrun, 0);
        check("abort idle busy", c_busy, 0);

        // Abort after the second strobe, then asynchronous reset in COLLECT.
        qc.delete();
        fd_snap = fdc;
        send_frame_c();
        wait_two_starts_c("abort reach send");
        abort_c = 1'b1;
        @(negedge clk); abort_c = 1'b0;
        repeat (100) @(negedge clk);
        check("abort no more starts", qc.size(), 2);
        check("abort busy", c_busy, 0);
        check("abort no frame_done", fdc - fd_snap, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst tx_start", c_tx_start, 0);
        check("mid rst tx_data", c_tx_data, 8'h00);
        check("mid rst busy", c_busy, 0);
        check("mid rst frame_done", c_frame_done, 0);
        check("mid rst overrun", c_overrun, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort beats a simultaneous rx_valid; next four bytes form the frame.
        abort_c = 1'b1; rx_valid_c = 1'b1; rx_data_c = 8'hFF;
        @(negedge clk);
        abort_c = 1'b0; rx_valid_c = 1'b0;
        qc.delete();
        fd_snap = fdc;
        send_frame_c();
        wait_fd_c(fd_snap + 1, "post-rst frame_done");
        repeat (3) @(negedge clk);
        check_frame_c("post-rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
